// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
package sevenseg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

endpackage

// File: rtl/sevenseg.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module sevenseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Scans a double-buffered hex value across DIGITS common-anode displays
// through a single shared decoder.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  blank_en,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int DW    = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DW-1:0]      disp_q, disp_d;
  logic [DW-1:0]      pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [DIGITS-1:0]  digit_sel_q, digit_sel_d;
  logic [6:0]         seg_q, seg_d;

  logic               tc;
  logic               wrap;
  logic               accept;
  logic [3:0]         nib;
  logic               blank_dig;
  logic               zacc;
  logic [6:0]         dec_seg;
  logic [DIGITS-1:0]  sel_next;

  sevenseg u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  // Walk from the top nibble down so zacc tracks "all higher digits zero".
  always_comb begin
    nib       = 4'h0;
    blank_dig = 1'b0;
    zacc      = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc = zacc && (disp_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib       = disp_q[4*i +: 4];
        blank_dig = blank_en && zacc && (i != 0);
      end
    end
  end

  always_comb begin
    tc         = (div_cnt_q == CNT_TC);
    wrap       = (state_q == SCAN) && tc && (idx_q == IDX_LAST);
    load_ready = !pend_vld_q;
    accept     = load_valid && load_ready;
    frame_done = wrap;

    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          disp_d    = load_data;
          state_d   = SCAN;
          div_cnt_d = '0;
          idx_d     = '0;
        end
      end
      SCAN: begin
        if (tc) begin
          div_cnt_d = '0;
          idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
        // Commit uses the old pend_vld, so a same-cycle load waits a frame.
        if (wrap && pend_vld_q) begin
          disp_d     = pend_q;
          pend_vld_d = 1'b0;
        end
        if (accept) begin
          pend_d     = load_data;
          pend_vld_d = 1'b1;
        end
      end
    endcase

    sel_next    = (state_q == SCAN) ? ~(DIGITS'(1) << idx_q) : '1;
    digit_sel_d = sel_next;
    if (state_q != SCAN || sel_next != digit_sel_q || blank_dig) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      digit_sel_q <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign digit_sel = digit_sel_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for the seven-segment scan controller.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        blank_en;
  logic [3:0]  digit_sel;
  logic [6:0]  seg;
  logic        frame_done;

  logic        f_load_valid;
  logic        f_load_ready;
  logic [15:0] f_load_data;
  logic [3:0]  f_digit_sel;
  logic [6:0]  f_seg;
  logic        f_frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_en   (blank_en),
    .digit_sel  (digit_sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  sevenseg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(1)) u_fast (
    .clk        (clk),
    .rst        (rst),
    .load_valid (f_load_valid),
    .load_ready (f_load_ready),
    .load_data  (f_load_data),
    .blank_en   (blank_en),
    .digit_sel  (f_digit_sel),
    .seg        (f_seg),
    .frame_done (f_frame_done)
  );

  typedef struct {
    logic [15:0]      data;
    logic             blank;
    logic [3:0][6:0]  seg;
  } vec_t;

  vec_t vecs [6];
  logic [3:0][3:0] sel_tab;

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    load_valid   = 1'b0;
    f_load_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic load(input logic [15:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    int first;
    int second;
    int npulse;

    sel_tab = {4'h7, 4'hB, 4'hD, 4'hE};
    vecs[0] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h00A5, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h12}};
    vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{16'h00A5, 1'b0, {7'h40, 7'h40, 7'h08, 7'h12}};
    vecs[4] = '{16'hF0E0, 1'b1, {7'h0E, 7'h40, 7'h06, 7'h40}};
    vecs[5] = '{16'h0B00, 1'b1, {7'h7F, 7'h03, 7'h40, 7'h40}};

    rst          = 1'b1;
    load_valid   = 1'b0;
    load_data    = '0;
    f_load_valid = 1'b0;
    f_load_data  = '0;
    blank_en     = 1'b0;
    #2;
    check("rst_sel", 16'(digit_sel), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_ready", 16'(load_ready), 16'h1);
    check("rst_fd", 16'(frame_done), 16'h0);
    step();
    rst = 1'b0;
    step();
    check("idle_sel", 16'(digit_sel), 16'hF);

    // Reset asserted mid-scan takes effect without a clock edge.
    load(16'h1234);
    step_n(6);
    check("pre_rst_sel", 16'(digit_sel), 16'hD);
    rst = 1'b1;
    #1;
    check("mid_rst_sel", 16'(digit_sel), 16'hF);
    check("mid_rst_seg", 16'(seg), 16'h7F);
    check("mid_rst_ready", 16'(load_ready), 16'h1);
    step();
    rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      do_reset();
      blank_en = vecs[v].blank;
      load(vecs[v].data);
      step_n(3);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("vec%0d_sel%0d", v, k), 16'(digit_sel),
              16'(sel_tab[k]));
        check($sformatf("vec%0d_seg%0d", v, k), 16'(seg),
              16'(vecs[v].seg[k]));
        step_n(4);
      end
    end
    blank_en = 1'b0;

    // Ghosting guard: seg dark exactly for the digit_sel change cycle.
    do_reset();
    load(16'h1234);
    step();
    check("ghost_e1_sel", 16'(digit_sel), 16'hE);
    check("ghost_e1_seg", 16'(seg), 16'h7F);
    step();
    check("ghost_e2_seg", 16'(seg), 16'h19);
    step_n(2);
    check("ghost_e4_seg", 16'(seg), 16'h19);
    step();
    check("ghost_e5_sel", 16'(digit_sel), 16'hD);
    check("ghost_e5_seg", 16'(seg), 16'h7F);
    step();
    check("ghost_e6_seg", 16'(seg), 16'h30);

    // frame_done period
    do_reset();
    load(16'h1234);
    first  = -1;
    second = -1;
    npulse = 0;
    for (int c = 1; c <= 40; c++) begin
      if (frame_done) begin
        npulse++;
        if (first < 0) first = c - 1;
        else if (second < 0) second = c - 1;
      end
      step();
    end
    check("fd_first", 16'(first), 16'd15);
    check("fd_second", 16'(second), 16'd31);
    check("fd_count", 16'(npulse), 16'd2);

    // Mid-frame load, plus a held-off second load.
    do_reset();
    load(16'h1234);
    step_n(5);
    load(16'hBEEF);
    check("beef_ready_low", 16'(load_ready), 16'h0);
    step();
    check("beef_old_sel", 16'(digit_sel), 16'hD);
    check("beef_old_seg", 16'(seg), 16'h30);
    load_valid = 1'b1;
    load_data  = 16'h5555;
    step_n(5);
    load_valid = 1'b0;
    check("holdoff_ready", 16'(load_ready), 16'h0);
    step_n(3);
    check("beef_fd", 16'(frame_done), 16'h1);
    check("beef_ready_fd", 16'(load_ready), 16'h0);
    step();
    check("beef_ready_up", 16'(load_ready), 16'h1);
    step_n(3);
    check("beef_new_sel", 16'(digit_sel), 16'hE);
    check("beef_new_seg0", 16'(seg), 16'h0E);
    step_n(12);
    check("beef_new_seg3", 16'(seg), 16'h03);

    // Load presented in the wrap cycle waits one more frame.
    do_reset();
    load(16'h1234);
    step_n(15);
    check("wrapld_fd", 16'(frame_done), 16'h1);
    load(16'h00A5);
    check("wrapld_ready", 16'(load_ready), 16'h0);
    step_n(3);
    check("wrapld_old_seg", 16'(seg), 16'h19);
    step_n(12);
    check("wrapld_fd2", 16'(frame_done), 16'h1);
    check("wrapld_ready2", 16'(load_ready), 16'h0);
    step();
    check("wrapld_ready3", 16'(load_ready), 16'h1);
    step_n(3);
    check("wrapld_new_seg", 16'(seg), 16'h12);

    // REFRESH_DIV=1: one digit per clock.
    do_reset();
    f_load_valid = 1'b1;
    f_load_data  = 16'h1234;
    step();
    f_load_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("fast_fd%0d", k), 16'(f_frame_done),
            16'((k % 4) == 0));
      step();
      check($sformatf("fast_sel%0d", k), 16'(f_digit_sel),
            16'(sel_tab[(k - 1) % 4]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
